vera_bus_master: RTL
====================

# vera_bus_master

Bus master for the VERA external register bus. Two requesters share it: the host port (0) and the demo sequencer (1), under round-robin arbitration. Each accepted command becomes one complete extbus read or write cycle with parameterised setup, strobe and hold phases, followed by a one-cycle response pulse. It sits between the demo control logic and the `vera` instance and replaces the static tie-offs on `extbus_*`.

## Interface
Parameters:
- `SETUP_CYC`, 1: cycles with `cs_n` low and address/data driven before the strobe (≥1).
- `STROBE_CYC`, 2: cycles with `rd_n`/`wr_n` low (≥1).
- `HOLD_CYC`, 1: cycles after the strobe with `cs_n` low and address/data held (≥1).

Ports:
- `clk` in 1: the only clock, the VERA pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req0_valid`/`req1_valid` in 1: command pending on requester 0/1.
- `req0_ready`/`req1_ready` out 1: command accepted this cycle.
- `req0_we`/`req1_we` in 1: 1 = write, 0 = read.
- `req0_addr`/`req1_addr` in 5: VERA register address.
- `req0_wdata`/`req1_wdata` in 8: write data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_id` out 1: requester the response belongs to.
- `rsp_rdata` out 8: read data; 0 for writes.
- `extbus_cs_n`, `extbus_rd_n`, `extbus_wr_n` out 1: bus strobes.
- `extbus_a` out 5: bus address.
- `extbus_d_out` out 8: write data.
- `extbus_d_oe` out 1: data driver enable, used by the top-level tristate.
- `extbus_d_in` in 8: read data from VERA.
- `extbus_irq_n` in 1: VERA interrupt, active low.
- `irq` out 1: synchronised, active-high interrupt.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A down-counter `cnt` is loaded with the phase length minus 1 on entry to each phase.
- IDLE:
  - `reqN_ready` is combinational: `(state==IDLE) && grant==N && reqN_valid`.
  - Grant rules:
    - Only one requester valid: that requester wins.
    - Both valid: the requester not in `last_grant` wins.
  - On accept: latch `we`, `addr`, `wdata` and `id`; set `last_grant` = `id`; go to SETUP.
- SETUP:
  - `cs_n`=0, `extbus_a`=addr, `rd_n`=`wr_n`=1.
  - Writes only: `d_oe`=1 and `d_out`=wdata.
  - Lasts SETUP_CYC cycles, then STROBE.
- STROBE:
  - Read: `rd_n`=0. Write: `wr_n`=0.
  - Lasts STROBE_CYC cycles.
  - Reads: `extbus_d_in` is sampled into `rsp_rdata` on the last STROBE cycle.
- HOLD:
  - Strobes high; `cs_n`, `a`, `d_out` and `d_oe` unchanged.
  - Lasts HOLD_CYC cycles, then IDLE with `rsp_valid`=1 for exactly one cycle and `rsp_id` = latched id.
- All `extbus_*` outputs come from flops, so they are glitch-free. In IDLE: `cs_n`=`rd_n`=`wr_n`=1, `d_oe`=0, and `a`/`d_out` keep their last values.
- `irq`: `extbus_irq_n` passes through a 2-flop synchroniser (flops reset to 1); `irq` = inverted synchroniser output.
- Reset values: `cs_n`=`rd_n`=`wr_n`=1, `a`=0, `d_out`=0, `d_oe`=0, `ready`s=0, `rsp_valid`=0, `rsp_id`=0, `rsp_rdata`=0, `irq`=0, `last_grant`=1 (requester 0 wins the first tie), state IDLE.
- Reset mid-transaction: the bus is released immediately (asynchronously). The command is dropped and no `rsp_valid` is issued.
- `reqN_valid` dropped before ready: no effect and no penalty. A requester must hold its command fields stable while valid.

## Timing
- Accept at cycle 0 (the ready&valid edge).
  - SETUP: cycles 1..S.
  - STROBE: cycles S+1..S+T.
  - HOLD: cycles S+T+1..S+T+H.
  - `rsp_valid`: cycle S+T+H+1.
  - Defaults: `cs_n` low cycles 1–4, strobe low cycles 2–3, response at cycle 5.
- In the `rsp_valid` cycle the FSM is in IDLE and may accept the next command. Back-to-back throughput is one transaction per S+T+H+1 cycles (5 at defaults).
- `cs_n` goes high for at least one cycle between transactions.
- `d_oe` rises together with `cs_n` falling and falls together with `cs_n` rising.
- Interrupt latency: 2 cycles from `extbus_irq_n` fall to `irq` high.

## Test plan
- Single write, requester 0, addr 0x1F, data 0xA5 at defaults:
  - `cs_n` low cycles 1–4, `wr_n` low cycles 2–3, `a`=0x1F, `d_out`=0xA5, `d_oe`=1 cycles 1–4.
  - `rsp_valid` at cycle 5 with id 0 and rdata 0x00.
- Single read, requester 1, addr 0x03, `extbus_d_in`=0x5C during the strobe:
  - `rd_n` low cycles 2–3, `d_oe`=0 throughout.
  - Response id 1, rdata 0x5C.
- Both requesters valid continuously, 6 writes each:
  - Grants alternate 0,1,0,1…, starting with 0.
  - `rsp_valid` every 5 cycles.
  - `cs_n` high exactly one cycle between transactions.
- Parameters S=2, T=3, H=2, one read:
  - `cs_n` low 7 cycles, `rd_n` low cycles 3–5.
  - Data sampled on cycle 5; `rsp_valid` at cycle 8.
- `reset_n` asserted during STROBE of a write:
  - Same cycle: `wr_n`/`cs_n` go to 1 and `d_oe` to 0 asynchronously; no `rsp_valid`.
  - After release, the next tie is granted to requester 0.
- `extbus_irq_n` low for 3 cycles, then high:
  - `irq` high after 2 cycles and stays high for 3 cycles.
  - `irq`=0 out of reset.

Source files
------------

// File: rtl/vera_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : vera_bus_master
// Description : Round-robin master for the VERA external register bus; turns
//               each accepted command into one timed read/write cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vera_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_we,
    input  logic [4:0] req0_addr,
    input  logic [7:0] req0_wdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_we,
    input  logic [4:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_rdata,
    output logic       extbus_cs_n,
    output logic       extbus_rd_n,
    output logic       extbus_wr_n,
    output logic [4:0] extbus_a,
    output logic [7:0] extbus_d_out,
    output logic       extbus_d_oe,
    input  logic [7:0] extbus_d_in,
    input  logic       extbus_irq_n,
    output logic       irq
);

    localparam int c_MAX_CYC = (SETUP_CYC > STROBE_CYC) ?
                               ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                               ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_SETUP_LD  = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STROBE_LD = c_CNT_W'(STROBE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD   = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_STROBE = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;

    logic       r_we;
    logic       r_id;
    logic       r_last_grant;
    logic       r_cs_n;
    logic       r_rd_n;
    logic       r_wr_n;
    logic       r_d_oe;
    logic [4:0] r_a;
    logic [7:0] r_d_out;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [7:0] r_rsp_rdata;
    logic [1:0] r_irq_sync;

    logic       w_idle;
    logic       w_grant;
    logic       w_accept;
    logic       w_sel_we;
    logic [4:0] w_sel_addr;
    logic [7:0] w_sel_wdata;
    logic       w_next_we;
    logic       w_phase_end;

    // Tie goes to whoever was not served last; a lone requester always wins.
    always_comb begin
        w_idle      = (r_state == c_IDLE);
        w_grant     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
        w_accept    = w_idle && (req0_valid || req1_valid);
        w_sel_we    = w_grant ? req1_we    : req0_we;
        w_sel_addr  = w_grant ? req1_addr  : req0_addr;
        w_sel_wdata = w_grant ? req1_wdata : req0_wdata;
        w_next_we   = w_accept ? w_sel_we : r_we;
        w_phase_end = (r_cnt == c_CNT_ZERO);
        req0_ready  = w_idle && !w_grant && req0_valid;
        req1_ready  = w_idle &&  w_grant && req1_valid;
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_SETUP;
                    w_next_cnt   = c_SETUP_LD;
                end
            end
            c_SETUP: begin
                if (w_phase_end) begin
                    w_next_state = c_STROBE;
                    w_next_cnt   = c_STROBE_LD;
                end else begin
                    w_next_cnt   = r_cnt - c_CNT_ONE;
                end
            end
            c_STROBE: begin
                if (w_phase_end) begin
                    w_next_state = c_HOLD;
                    w_next_cnt   = c_HOLD_LD;
                end else begin
                    w_next_cnt   = r_cnt - c_CNT_ONE;
                end
            end
            c_HOLD: begin
                if (w_phase_end) begin
                    w_next_state = c_IDLE;
                end else begin
                    w_next_cnt   = r_cnt - c_CNT_ONE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_cnt   <= c_CNT_ZERO;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Bus strobes are registered from the next state so they change on the
    // same edge as the phase itself and never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we         <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_cs_n       <= 1'b1;
            r_rd_n       <= 1'b1;
            r_wr_n       <= 1'b1;
            r_d_oe       <= 1'b0;
            r_a          <= 5'd0;
            r_d_out      <= 8'd0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_rdata  <= 8'd0;
        end else begin
            r_cs_n      <= (w_next_state == c_IDLE);
            r_rd_n      <= !((w_next_state == c_STROBE) && !w_next_we);
            r_wr_n      <= !((w_next_state == c_STROBE) &&  w_next_we);
            r_d_oe      <= (w_next_state != c_IDLE) && w_next_we;
            r_rsp_valid <= (r_state == c_HOLD) && w_phase_end;
            if ((r_state == c_HOLD) && w_phase_end) begin
                r_rsp_id <= r_id;
            end
            if (w_accept) begin
                r_we         <= w_sel_we;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
                r_a          <= w_sel_addr;
                r_rsp_rdata  <= 8'd0;
                if (w_sel_we) begin
                    r_d_out <= w_sel_wdata;
                end
            end
            if ((r_state == c_STROBE) && w_phase_end && !r_we) begin
                r_rsp_rdata <= extbus_d_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_sync <= 2'b11;
        end else begin
            r_irq_sync <= {r_irq_sync[0], extbus_irq_n};
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_rdata    = r_rsp_rdata;
    assign extbus_cs_n  = r_cs_n;
    assign extbus_rd_n  = r_rd_n;
    assign extbus_wr_n  = r_wr_n;
    assign extbus_a     = r_a;
    assign extbus_d_out = r_d_out;
    assign extbus_d_oe  = r_d_oe;
    assign irq          = ~r_irq_sync[1];

endmodule
`default_nettype wire
